// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the LEGv8 multicycle sequencer: state encodings,
// instruction classes, ALU/sign-extend codes, opcode match patterns and the
// per-instruction control word.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LDUR = 3'd1,
    CLS_STUR = 3'd2,
    CLS_CBZ  = 3'd3,
    CLS_B    = 3'd4
  } insn_class_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MOVZ  = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [2:0] SGN_I  = 3'b000;  // ALU immediate
  localparam logic [2:0] SGN_D  = 3'b001;  // load/store offset
  localparam logic [2:0] SGN_CB = 3'b010;  // conditional branch offset
  localparam logic [2:0] SGN_B  = 3'b011;  // unconditional branch offset
  localparam logic [2:0] SGN_IW = 3'b100;  // MOVZ wide immediate

  typedef struct packed {
    logic        reg2loc;
    logic        alusrc;
    logic        mem2reg;
    logic [3:0]  aluop;
    logic [2:0]  signop;
    insn_class_t cls;
  } ctrl_word_t;

  // Opcode patterns as value/mask pairs; a cleared mask bit is a don't-care.
  localparam logic [10:0] OP_LDUR_V   = 11'b11111000010, OP_LDUR_M   = 11'b11111111111;
  localparam logic [10:0] OP_STUR_V   = 11'b11111000000, OP_STUR_M   = 11'b11111111111;
  localparam logic [10:0] OP_ADDREG_V = 11'b10001011000, OP_ADDREG_M = 11'b11111111111;
  localparam logic [10:0] OP_ADDIMM_V = 11'b10010001000, OP_ADDIMM_M = 11'b11111111110;
  localparam logic [10:0] OP_SUBREG_V = 11'b11001011000, OP_SUBREG_M = 11'b11111111111;
  localparam logic [10:0] OP_SUBIMM_V = 11'b11010001000, OP_SUBIMM_M = 11'b11111111110;
  localparam logic [10:0] OP_ANDREG_V = 11'b10001010000, OP_ANDREG_M = 11'b11111111111;
  localparam logic [10:0] OP_ORRREG_V = 11'b10101010000, OP_ORRREG_M = 11'b11111111111;
  localparam logic [10:0] OP_CBZ_V    = 11'b10110100000, OP_CBZ_M    = 11'b11111111000;
  localparam logic [10:0] OP_B_V      = 11'b00010100000, OP_B_M      = 11'b11111100000;
  localparam logic [10:0] OP_MOVZ_V   = 11'b11010010100, OP_MOVZ_M   = 11'b11111111100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/multicycle_control_insn_decode.sv
// Combinational opcode decoder.
//   opcode : IR[31:21]
//   ctrl   : control word for the matched instruction ('0 when unmatched)
//   valid  : 1 when the opcode matched a supported instruction
module insn_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_word_t  ctrl,
  output logic        valid
);

  // if/else chain keeps first-match priority in the listed order.
  always_comb begin
    ctrl  = '0;
    valid = 1'b1;
    if (op_match(opcode, OP_LDUR_V, OP_LDUR_M)) begin
      ctrl.aluop = ALU_ADD; ctrl.signop = SGN_D; ctrl.alusrc = 1'b1;
      ctrl.mem2reg = 1'b1; ctrl.cls = CLS_LDUR;
    end else if (op_match(opcode, OP_STUR_V, OP_STUR_M)) begin
      ctrl.aluop = ALU_ADD; ctrl.signop = SGN_D; ctrl.alusrc = 1'b1;
      ctrl.reg2loc = 1'b1; ctrl.cls = CLS_STUR;
    end else if (op_match(opcode, OP_ADDREG_V, OP_ADDREG_M)) begin
      ctrl.aluop = ALU_ADD;
    end else if (op_match(opcode, OP_ADDIMM_V, OP_ADDIMM_M)) begin
      ctrl.aluop = ALU_ADD; ctrl.alusrc = 1'b1; ctrl.signop = SGN_I;
    end else if (op_match(opcode, OP_SUBREG_V, OP_SUBREG_M)) begin
      ctrl.aluop = ALU_SUB;
    end else if (op_match(opcode, OP_SUBIMM_V, OP_SUBIMM_M)) begin
      ctrl.aluop = ALU_SUB; ctrl.alusrc = 1'b1; ctrl.signop = SGN_I;
    end else if (op_match(opcode, OP_ANDREG_V, OP_ANDREG_M)) begin
      ctrl.aluop = ALU_AND;
    end else if (op_match(opcode, OP_ORRREG_V, OP_ORRREG_M)) begin
      ctrl.aluop = ALU_ORR;
    end else if (op_match(opcode, OP_CBZ_V, OP_CBZ_M)) begin
      ctrl.aluop = ALU_PASSB; ctrl.signop = SGN_CB; ctrl.reg2loc = 1'b1;
      ctrl.cls = CLS_CBZ;
    end else if (op_match(opcode, OP_B_V, OP_B_M)) begin
      ctrl.signop = SGN_B; ctrl.cls = CLS_B;
    end else if (op_match(opcode, OP_MOVZ_V, OP_MOVZ_M)) begin
      ctrl.aluop = ALU_MOVZ; ctrl.signop = SGN_IW; ctrl.alusrc = 1'b1;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle sequencer. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshaking with slow instruction/data memories.
//   CLK, resetl            : clock, async active-low reset
//   opcode, zero           : IR[31:21] and ALU zero flag
//   imem_ready, dmem_ready : memory completion handshakes
//   imem_req, dmem_req     : memory requests
//   irwrite, pcwrite, pc_src, instr_done : IR/PC control and retire pulse
//   reg2loc..memwrite, aluop, signop     : datapath control word
//   halted, state          : sticky fault indicator and debug state
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned WAIT_W = 8
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pc_src,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic [3:0]  aluop,
  output logic [2:0]  signop,
  output logic        instr_done,
  output logic        halted,
  output logic [2:0]  state
);

  // Timeout fires on the cycle that would carry the counter to all-ones.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((2 ** WAIT_W) - 2);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_q;
  ctrl_word_t        ctrl_q;
  ctrl_word_t        dec_ctrl;
  logic              dec_valid;
  logic              wait_last;

  insn_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec_ctrl),
    .valid  (dec_valid)
  );

  assign wait_last = (wait_q == WAIT_LAST);
  assign state     = state_q;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            state_q <= ST_DECODE;
            wait_q  <= '0;
          end else if (wait_last) begin
            state_q <= ST_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          if (dec_valid) begin
            ctrl_q  <= dec_ctrl;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_HALT;
          end
        end
        ST_EXEC: begin
          case (ctrl_q.cls)
            CLS_B, CLS_CBZ: begin
              state_q <= ST_FETCH;
              wait_q  <= '0;
              ctrl_q  <= '0;
            end
            CLS_LDUR, CLS_STUR: begin
              state_q <= ST_MEM;
              wait_q  <= '0;
            end
            default: state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (ctrl_q.cls == CLS_STUR) begin
              state_q <= ST_FETCH;
              wait_q  <= '0;
              ctrl_q  <= '0;
            end else begin
              state_q <= ST_WB;
            end
          end else if (wait_last) begin
            state_q <= ST_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          wait_q  <= '0;
          ctrl_q  <= '0;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Handshake outputs react to ready within the same cycle; the datapath
  // word comes from the latched control word. Everything is forced low
  // while reset is asserted, including the FETCH request.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    aluop      = '0;
    signop     = '0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (resetl) begin
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        reg2loc = ctrl_q.reg2loc;
        alusrc  = ctrl_q.alusrc;
        mem2reg = ctrl_q.mem2reg;
        aluop   = ctrl_q.aluop;
        signop  = ctrl_q.signop;
      end
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          irwrite  = imem_ready;
        end
        ST_EXEC: begin
          if (ctrl_q.cls == CLS_B) begin
            pcwrite    = 1'b1;
            pc_src     = 1'b1;
            instr_done = 1'b1;
          end else if (ctrl_q.cls == CLS_CBZ) begin
            pcwrite    = 1'b1;
            pc_src     = zero;
            instr_done = 1'b1;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          memread  = (ctrl_q.cls == CLS_LDUR);
          memwrite = (ctrl_q.cls == CLS_STUR);
          if (dmem_ready && ctrl_q.cls == CLS_STUR) begin
            pcwrite    = 1'b1;
            instr_done = 1'b1;
          end
        end
        ST_WB: begin
          regwrite   = 1'b1;
          pcwrite    = 1'b1;
          instr_done = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int unsigned LIM = 7;  // 2^3-1 with WAIT_W=3

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd7;
  localparam int unsigned K_ALU = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [10:0] opcode;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, irwrite, pcwrite, pc_src;
  logic        reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
  logic [3:0]  aluop;
  logic [2:0]  signop;
  logic        instr_done, halted;
  logic [2:0]  state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  typedef struct {
    int unsigned start;
    int unsigned lat;
    logic        pcs;
  } exp_t;
  exp_t sb[$];

  multicycle_control #(.WAIT_W(3)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .irwrite(irwrite),
    .pcwrite(pcwrite), .pc_src(pc_src), .reg2loc(reg2loc), .alusrc(alusrc),
    .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .aluop(aluop), .signop(signop),
    .instr_done(instr_done), .halted(halted), .state(state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {pad, state, imem_req, irwrite, dmem_req, memread, memwrite, regwrite,
  //  pcwrite, mem2reg, halted, aluop, signop, alusrc, reg2loc}
  function automatic logic [31:0] obs_vec();
    return {11'b0, state, imem_req, irwrite, dmem_req, memread, memwrite,
            regwrite, pcwrite, mem2reg, halted, aluop, signop, alusrc, reg2loc};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Observe the current cycle mid-period; retire pulses pop the scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge CLK);
    cyc++;
    check("inv_pcwrite_eq_done", 32'(pcwrite), 32'(instr_done));
    check("inv_regwrite_memwrite", 32'(regwrite & memwrite), 32'd0);
    check("inv_imem_dmem_req", 32'(imem_req & dmem_req), 32'd0);
    if (instr_done) begin
      check("sb_nonempty_at_done", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("retire_latency", cyc - e.start + 1, e.lat);
        check("retire_pc_src", 32'(pc_src), 32'(e.pcs));
      end
    end
  endtask

  task automatic do_reset();
    resetl = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0; opcode = '0;
    sample();
    check("reset_outputs", obs_vec(), 32'd0);
    tick();
    resetl = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  // fw: fetch cycles without ready (>=LIM times out), mw: MEM cycles without
  // ready (>=LIM times out). e_*: expected datapath word from the opcode table.
  task automatic run_insn(input logic [10:0] op, input logic z,
                          input int unsigned fw, input int unsigned mw,
                          input int unsigned kind, input logic [3:0] e_a,
                          input logic [2:0] e_s, input logic e_as, input logic e_rl);
    logic [2:0] st_q[$];
    logic       ir_q[$];
    logic       dr_q[$];
    logic       retire;
    logic [2:0] est;
    logic ireq, irw, dreq, mrd, mwr, rw, pcw, m2r, hlt, as, rl;
    logic [3:0] a;
    logic [2:0] s;
    exp_t e;
    retire = 1'b1;
    for (int unsigned i = 0; i < fw && i < LIM; i++) begin
      st_q.push_back(S_F); ir_q.push_back(1'b0); dr_q.push_back(1'b0);
    end
    if (fw >= LIM) begin
      retire = 1'b0;
      repeat (2) begin st_q.push_back(S_H); ir_q.push_back(1'b1); dr_q.push_back(1'b1); end
    end else begin
      st_q.push_back(S_F); ir_q.push_back(1'b1); dr_q.push_back(1'b0);
      st_q.push_back(S_D); ir_q.push_back(1'b0); dr_q.push_back(1'b0);
      if (kind == K_ILL) begin
        retire = 1'b0;
        repeat (3) begin st_q.push_back(S_H); ir_q.push_back(1'b1); dr_q.push_back(1'b1); end
      end else begin
        st_q.push_back(S_E); ir_q.push_back(1'b0); dr_q.push_back(1'b0);
        if (kind == K_LD || kind == K_ST) begin
          for (int unsigned j = 0; j < mw && j < LIM; j++) begin
            st_q.push_back(S_M); ir_q.push_back(1'b0); dr_q.push_back(1'b0);
          end
          if (mw >= LIM) begin
            retire = 1'b0;
            repeat (2) begin st_q.push_back(S_H); ir_q.push_back(1'b1); dr_q.push_back(1'b1); end
          end else begin
            st_q.push_back(S_M); ir_q.push_back(1'b0); dr_q.push_back(1'b1);
            if (kind == K_LD) begin
              st_q.push_back(S_W); ir_q.push_back(1'b0); dr_q.push_back(1'b0);
            end
          end
        end else if (kind == K_ALU) begin
          st_q.push_back(S_W); ir_q.push_back(1'b0); dr_q.push_back(1'b0);
        end
      end
    end
    if (retire) begin
      e.start = cyc + 1;
      e.lat   = st_q.size();
      e.pcs   = (kind == K_B) ? 1'b1 : (kind == K_CBZ) ? z : 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < st_q.size(); i++) begin
      opcode = op; zero = z; imem_ready = ir_q[i]; dmem_ready = dr_q[i];
      est = st_q[i];
      {ireq, irw, dreq, mrd, mwr, rw, pcw, m2r, hlt, as, rl} = '0;
      a = '0; s = '0;
      if (est == S_E || est == S_M || est == S_W) begin
        a = e_a; s = e_s; as = e_as; rl = e_rl; m2r = (kind == K_LD);
      end
      case (est)
        S_F: begin ireq = 1'b1; irw = ir_q[i]; end
        S_E: pcw = (kind == K_B || kind == K_CBZ);
        S_M: begin
          dreq = 1'b1; mrd = (kind == K_LD); mwr = (kind == K_ST);
          pcw = (kind == K_ST) && dr_q[i];
        end
        S_W: begin rw = 1'b1; pcw = 1'b1; end
        S_H: hlt = 1'b1;
        default: ;
      endcase
      sample();
      check($sformatf("op%b_cyc%0d", op, i), obs_vec(),
            {11'b0, est, ireq, irw, dreq, mrd, mwr, rw, pcw, m2r, hlt, a, s, as, rl});
      tick();
    end
  endtask

  initial begin
    resetl = 1'b0; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick();
    do_reset();

    // Back-to-back ADDREG with zero-wait memories
    run_insn(11'b10001011000, 1'b0, 0, 0, K_ALU, 4'b0010, 3'b000, 1'b0, 1'b0);
    run_insn(11'b10001011000, 1'b0, 0, 0, K_ALU, 4'b0010, 3'b000, 1'b0, 1'b0);
    // LDUR with three MEM wait cycles
    run_insn(11'b11111000010, 1'b0, 0, 3, K_LD,  4'b0010, 3'b001, 1'b1, 1'b0);
    // CBZ taken / not taken
    run_insn(11'b10110100000, 1'b1, 0, 0, K_CBZ, 4'b0111, 3'b010, 1'b0, 1'b1);
    run_insn(11'b10110100101, 1'b0, 0, 0, K_CBZ, 4'b0111, 3'b010, 1'b0, 1'b1);
    // STUR then B
    run_insn(11'b11111000000, 1'b0, 0, 0, K_ST,  4'b0010, 3'b001, 1'b1, 1'b1);
    run_insn(11'b00010111111, 1'b0, 0, 0, K_B,   4'b0000, 3'b011, 1'b0, 1'b0);
    // Remaining ALU forms
    run_insn(11'b10010001001, 1'b0, 0, 0, K_ALU, 4'b0010, 3'b000, 1'b1, 1'b0);
    run_insn(11'b11010001000, 1'b0, 0, 0, K_ALU, 4'b0110, 3'b000, 1'b1, 1'b0);
    run_insn(11'b11001011000, 1'b0, 0, 0, K_ALU, 4'b0110, 3'b000, 1'b0, 1'b0);
    run_insn(11'b10001010000, 1'b0, 0, 0, K_ALU, 4'b0000, 3'b000, 1'b0, 1'b0);
    run_insn(11'b10101010000, 1'b0, 0, 0, K_ALU, 4'b0001, 3'b000, 1'b0, 1'b0);
    run_insn(11'b11010010110, 1'b0, 0, 0, K_ALU, 4'b0011, 3'b100, 1'b1, 1'b0);
    // Ready arriving on the limit cycle still wins (MEM and FETCH)
    run_insn(11'b11111000010, 1'b0, 0, 6, K_LD,  4'b0010, 3'b001, 1'b1, 1'b0);
    run_insn(11'b10001011000, 1'b0, 6, 0, K_ALU, 4'b0010, 3'b000, 1'b0, 1'b0);
    // MEM timeout on a store
    run_insn(11'b11111000000, 1'b0, 0, LIM, K_ST, 4'b0010, 3'b001, 1'b1, 1'b1);
    do_reset();
    // FETCH timeout
    run_insn(11'b10001011000, 1'b0, LIM, 0, K_ALU, 4'b0010, 3'b000, 1'b0, 1'b0);
    do_reset();
    // Illegal opcode, then an async reset pulse between clock edges
    run_insn(11'b00000000000, 1'b0, 0, 0, K_ILL, 4'b0000, 3'b000, 1'b0, 1'b0);
    imem_ready = 1'b0; dmem_ready = 1'b0;
    #3;
    resetl = 1'b0;
    #1;
    check("async_reset_outputs", obs_vec(), 32'd0);
    #2;
    resetl = 1'b1;
    tick();
    run_insn(11'b10001011000, 1'b0, 0, 0, K_ALU, 4'b0010, 3'b000, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
